// File: rtl/ex_stage_mc.sv
// Execute stage with operand forwarding, single-cycle ALU and a sequential
// shift-add multiplier that stalls upstream until its product is taken.
module ex_stage_mc #(
  parameter int WIDTH = 10,
  parameter int RSEL  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] rs_in,
  input  logic [WIDTH-1:0] rt_in,
  input  logic [WIDTH-1:0] signextimm,
  input  logic [WIDTH-1:0] ALU_EX,
  input  logic [WIDTH-1:0] ALU_M,
  input  logic [WIDTH-1:0] Mem_M,
  input  logic [2:0]       alu_sel,
  input  logic             imm_sel,
  input  logic [RSEL-1:0]  rd_sel1_in,
  input  logic [RSEL-1:0]  rd_sel2_in,
  input  logic [RSEL-1:0]  write_sel_EX,
  input  logic [RSEL-1:0]  write_sel_M,
  input  logic [RSEL-1:0]  reg_writesel_in,
  input  logic             reg_write_en_EX,
  input  logic             MemtoReg_EX,
  input  logic             reg_write_en_M,
  input  logic             MemtoReg_M,
  input  logic             reg_write_en_in,
  input  logic             RAM_writeEnable_in,
  input  logic             MemtoReg_in,
  input  logic             cache_Ready,
  input  logic             flush,
  output logic             stall_out,
  output logic [WIDTH-1:0] rs_out,
  output logic [WIDTH-1:0] rt_out,
  output logic [WIDTH-1:0] ALU_result,
  output logic [RSEL-1:0]  reg_writesel_out,
  output logic             reg_write_en_out,
  output logic             RAM_writeEnable_out,
  output logic             MemtoReg_out,
  output logic             valid_out,
  output logic             zero_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mul_a, mul_b, acc;
  logic [WIDTH-1:0] m_rs, m_rt;
  logic [RSEL-1:0]  m_wsel;
  logic             m_we, m_ram, m_m2r;

  logic [WIDTH-1:0] fwd_a, fwd_b, op_b, alu_res;
  logic             is_mul, accept;

  // EX-stage producer wins over M; a load in EX cannot forward yet.
  always_comb begin
    fwd_a = rs_in;
    if (reg_write_en_EX && !MemtoReg_EX && write_sel_EX == rd_sel1_in)
      fwd_a = ALU_EX;
    else if (reg_write_en_M && write_sel_M == rd_sel1_in)
      fwd_a = MemtoReg_M ? Mem_M : ALU_M;
    fwd_b = rt_in;
    if (reg_write_en_EX && !MemtoReg_EX && write_sel_EX == rd_sel2_in)
      fwd_b = ALU_EX;
    else if (reg_write_en_M && write_sel_M == rd_sel2_in)
      fwd_b = MemtoReg_M ? Mem_M : ALU_M;
    op_b = imm_sel ? signextimm : fwd_b;
  end

  always_comb begin
    alu_res = '0;
    case (alu_sel)
      3'b000: alu_res = fwd_a + op_b;
      3'b001: alu_res = fwd_a - op_b;
      3'b010: alu_res = fwd_a & op_b;
      3'b011: alu_res = fwd_a | op_b;
      3'b100: alu_res[0] = (fwd_a < op_b);
      3'b110: alu_res = fwd_a << op_b[3:0];
      3'b111: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  assign is_mul    = in_valid && (alu_sel == 3'b101);
  assign accept    = (state == IDLE) && is_mul && !flush;
  assign stall_out = reset && (accept || state == MUL || (state == DONE && !cache_Ready));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      mul_a               <= '0;
      mul_b               <= '0;
      acc                 <= '0;
      m_rs                <= '0;
      m_rt                <= '0;
      m_wsel              <= '0;
      m_we                <= 1'b0;
      m_ram               <= 1'b0;
      m_m2r               <= 1'b0;
      rs_out              <= '0;
      rt_out              <= '0;
      ALU_result          <= '0;
      reg_writesel_out    <= '0;
      reg_write_en_out    <= 1'b0;
      RAM_writeEnable_out <= 1'b0;
      MemtoReg_out        <= 1'b0;
      valid_out           <= 1'b0;
      zero_out            <= 1'b0;
    end else if (flush) begin
      state               <= IDLE;
      cnt                 <= '0;
      valid_out           <= 1'b0;
      reg_write_en_out    <= 1'b0;
      RAM_writeEnable_out <= 1'b0;
      MemtoReg_out        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state  <= MUL;
          cnt    <= '0;
          acc    <= '0;
          mul_a  <= fwd_a;
          mul_b  <= op_b;
          m_rs   <= fwd_a;
          m_rt   <= op_b;
          m_wsel <= reg_writesel_in;
          m_we   <= reg_write_en_in;
          m_ram  <= RAM_writeEnable_in;
          m_m2r  <= MemtoReg_in;
        end
        MUL: begin
          acc   <= acc + (mul_b[0] ? mul_a : '0);
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
          else                       cnt   <= cnt + CW'(1);
        end
        DONE: if (cache_Ready) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (cache_Ready) begin
        if (state == DONE) begin
          ALU_result          <= acc;
          zero_out            <= (acc == '0);
          rs_out              <= m_rs;
          rt_out              <= m_rt;
          reg_writesel_out    <= m_wsel;
          reg_write_en_out    <= m_we;
          RAM_writeEnable_out <= m_ram;
          MemtoReg_out        <= m_m2r;
          valid_out           <= 1'b1;
        end else if (state == IDLE && in_valid && !is_mul) begin
          ALU_result          <= alu_res;
          zero_out            <= (alu_res == '0);
          rs_out              <= fwd_a;
          rt_out              <= op_b;
          reg_writesel_out    <= reg_writesel_in;
          reg_write_en_out    <= reg_write_en_in;
          RAM_writeEnable_out <= RAM_writeEnable_in;
          MemtoReg_out        <= MemtoReg_in;
          valid_out           <= 1'b1;
        end else begin
          valid_out           <= 1'b0;
          reg_write_en_out    <= 1'b0;
          RAM_writeEnable_out <= 1'b0;
          MemtoReg_out        <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Scoreboard bench for ex_stage_mc: expected results are queued when an
// instruction is driven and compared when the EX register presents them.
module tb_ex_stage_mc;
  localparam int W = 10;
  localparam int R = 3;

  logic         clk, reset, in_valid, imm_sel;
  logic [W-1:0] rs_in, rt_in, signextimm, ALU_EX, ALU_M, Mem_M;
  logic [2:0]   alu_sel;
  logic [R-1:0] rd_sel1_in, rd_sel2_in, write_sel_EX, write_sel_M, reg_writesel_in;
  logic         reg_write_en_EX, MemtoReg_EX, reg_write_en_M, MemtoReg_M;
  logic         reg_write_en_in, RAM_writeEnable_in, MemtoReg_in;
  logic         cache_Ready, flush, stall_out;
  logic [W-1:0] rs_out, rt_out, ALU_result;
  logic [R-1:0] reg_writesel_out;
  logic         reg_write_en_out, RAM_writeEnable_out, MemtoReg_out, valid_out, zero_out;

  ex_stage_mc #(.WIDTH(W), .RSEL(R)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .rs_in(rs_in), .rt_in(rt_in), .signextimm(signextimm),
    .ALU_EX(ALU_EX), .ALU_M(ALU_M), .Mem_M(Mem_M),
    .alu_sel(alu_sel), .imm_sel(imm_sel),
    .rd_sel1_in(rd_sel1_in), .rd_sel2_in(rd_sel2_in),
    .write_sel_EX(write_sel_EX), .write_sel_M(write_sel_M), .reg_writesel_in(reg_writesel_in),
    .reg_write_en_EX(reg_write_en_EX), .MemtoReg_EX(MemtoReg_EX),
    .reg_write_en_M(reg_write_en_M), .MemtoReg_M(MemtoReg_M),
    .reg_write_en_in(reg_write_en_in), .RAM_writeEnable_in(RAM_writeEnable_in),
    .MemtoReg_in(MemtoReg_in), .cache_Ready(cache_Ready), .flush(flush),
    .stall_out(stall_out), .rs_out(rs_out), .rt_out(rt_out), .ALU_result(ALU_result),
    .reg_writesel_out(reg_writesel_out), .reg_write_en_out(reg_write_en_out),
    .RAM_writeEnable_out(RAM_writeEnable_out), .MemtoReg_out(MemtoReg_out),
    .valid_out(valid_out), .zero_out(zero_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res, rs, rt;
    logic [R-1:0] wsel;
    logic         we, ram, m2r;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [9:0] ref_alu(input logic [2:0] op, input logic [9:0] a, input logic [9:0] b);
    logic [31:0] x, y, r;
    x = {22'b0, a};
    y = {22'b0, b};
    case (op)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = (x < y) ? 32'd1 : 32'd0;
      3'd5: r = x * y;
      3'd6: r = x << (y & 32'd15);
      default: r = y;
    endcase
    return r[9:0];
  endfunction

  function automatic logic [37:0] pack_exp(input exp_t x);
    return {1'b1, x.we, x.ram, x.m2r, (x.res == '0), x.wsel, x.rs, x.rt, x.res};
  endfunction

  function automatic logic [37:0] pack_got();
    return {valid_out, reg_write_en_out, RAM_writeEnable_out, MemtoReg_out, zero_out,
            reg_writesel_out, rs_out, rt_out, ALU_result};
  endfunction

  function automatic exp_t mk(input logic [9:0] res, input logic [9:0] a, input logic [9:0] b);
    exp_t x;
    x.res = res; x.rs = a; x.rt = b;
    x.wsel = reg_writesel_in; x.we = reg_write_en_in;
    x.ram = RAM_writeEnable_in; x.m2r = MemtoReg_in;
    return x;
  endfunction

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_defaults;
    in_valid = 1'b0; imm_sel = 1'b0; alu_sel = 3'd0;
    rs_in = '0; rt_in = '0; signextimm = '0; ALU_EX = '0; ALU_M = '0; Mem_M = '0;
    rd_sel1_in = 3'd1; rd_sel2_in = 3'd2; write_sel_EX = 3'd7; write_sel_M = 3'd6;
    reg_writesel_in = 3'd3;
    reg_write_en_EX = 1'b0; MemtoReg_EX = 1'b0; reg_write_en_M = 1'b0; MemtoReg_M = 1'b0;
    reg_write_en_in = 1'b1; RAM_writeEnable_in = 1'b0; MemtoReg_in = 1'b0;
    cache_Ready = 1'b1; flush = 1'b0;
  endtask

  // Drive a non-forwarded instruction and queue its expected result.
  task automatic issue(input logic [2:0] op, input logic [9:0] a, input logic [9:0] b);
    in_valid = 1'b1; alu_sel = op; rs_in = a; rt_in = b;
    sb.push_back(mk(ref_alu(op, a, b), a, b));
  endtask

  task automatic test_reset;
    set_defaults();
    reset = 1'b0;
    in_valid = 1'b1; alu_sel = 3'b101;
    #3;
    total++;
    if (pack_got() !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", pack_got()); end
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    tick();
    total++;
    if (pack_got() !== '0) begin bad++; $display("FAIL reset_hold_edge: got %h want 0", pack_got()); end
    reset = 1'b1;
    set_defaults();
  endtask

  task automatic test_forward;
    set_defaults();
    rd_sel1_in = 3'd5; rd_sel2_in = 3'd2;
    write_sel_EX = 3'd5; reg_write_en_EX = 1'b1; MemtoReg_EX = 1'b0;
    write_sel_M = 3'd5; reg_write_en_M = 1'b1; MemtoReg_M = 1'b1;
    ALU_EX = 10'd3; Mem_M = 10'd9; rs_in = 10'd100; rt_in = 10'd1;
    alu_sel = 3'd0; in_valid = 1'b1;
    sb.push_back(mk(10'd4, 10'd3, 10'd1));
    tick();
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL fwd_prio: got %h want nothing queued", pack_got()); end
    else begin e = sb.pop_front();
      if (pack_got() !== pack_exp(e)) begin bad++; $display("FAIL fwd_prio: got %h want %h", pack_got(), pack_exp(e)); end
    end
    // B source: EX beats M ALU; then an EX load defers to M ALU.
    rd_sel1_in = 3'd1; rd_sel2_in = 3'd4; write_sel_EX = 3'd4; write_sel_M = 3'd4;
    MemtoReg_M = 1'b0; ALU_EX = 10'd20; ALU_M = 10'd50;
    sb.push_back(mk(10'd120, 10'd100, 10'd20));
    tick();
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL fwd_b_ex: got %h want nothing queued", pack_got()); end
    else begin e = sb.pop_front();
      if (pack_got() !== pack_exp(e)) begin bad++; $display("FAIL fwd_b_ex: got %h want %h", pack_got(), pack_exp(e)); end
    end
    MemtoReg_EX = 1'b1;
    sb.push_back(mk(10'd150, 10'd100, 10'd50));
    tick();
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL fwd_b_m: got %h want nothing queued", pack_got()); end
    else begin e = sb.pop_front();
      if (pack_got() !== pack_exp(e)) begin bad++; $display("FAIL fwd_b_m: got %h want %h", pack_got(), pack_exp(e)); end
    end
    set_defaults();
  endtask

  task automatic test_m_load;
    set_defaults();
    rd_sel1_in = 3'd5; rd_sel2_in = 3'd2;
    write_sel_M = 3'd5; reg_write_en_M = 1'b1; MemtoReg_M = 1'b1;
    Mem_M = 10'd9; ALU_M = 10'd77; rs_in = 10'd100; rt_in = 10'd2;
    alu_sel = 3'd1; in_valid = 1'b1;
    sb.push_back(mk(10'd7, 10'd9, 10'd2));
    tick();
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL m_load: got %h want nothing queued", pack_got()); end
    else begin e = sb.pop_front();
      if (pack_got() !== pack_exp(e)) begin bad++; $display("FAIL m_load: got %h want %h", pack_got(), pack_exp(e)); end
    end
    imm_sel = 1'b1; signextimm = 10'd4; rd_sel2_in = 3'd5;
    sb.push_back(mk(10'd5, 10'd9, 10'd4));
    tick();
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL m_load_imm: got %h want nothing queued", pack_got()); end
    else begin e = sb.pop_front();
      if (pack_got() !== pack_exp(e)) begin bad++; $display("FAIL m_load_imm: got %h want %h", pack_got(), pack_exp(e)); end
    end
    set_defaults();
  endtask

  task automatic test_back_to_back;
    int unsigned d_op[11] = '{0, 1, 4, 4, 4, 6, 6, 6, 2, 3, 7};
    int unsigned d_a[11]  = '{1023, 0, 5, 4, 1023, 1, 1, 3, 'h3f0, 'h201, 0};
    int unsigned d_b[11]  = '{1, 1, 5, 5, 0, 9, 10, 15, 'h0ff, 'h012, 777};
    logic [2:0] op;
    set_defaults();
    for (int i = 0; i < 25; i++) begin
      reg_writesel_in = 3'($urandom_range(0, 7));
      reg_write_en_in = 1'($urandom_range(0, 1));
      RAM_writeEnable_in = 1'($urandom_range(0, 1));
      MemtoReg_in = 1'($urandom_range(0, 1));
      if (i < 11) issue(3'(d_op[i]), 10'(d_a[i]), 10'(d_b[i]));
      else begin
        op = 3'($urandom_range(0, 6));
        if (op == 3'd5) op = 3'd7;
        issue(op, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
      end
      tick();
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL alu_b2b[%0d]: got %h want nothing queued", i, pack_got()); end
      else begin e = sb.pop_front();
        if (pack_got() !== pack_exp(e)) begin bad++; $display("FAIL alu_b2b[%0d]: got %h want %h", i, pack_got(), pack_exp(e)); end
      end
    end
    set_defaults();
  endtask

  task automatic test_multiply(input logic [9:0] a, input logic [9:0] b);
    int edges, stalls;
    set_defaults();
    issue(3'b101, a, b);
    edges = 0; stalls = 0;
    while (edges < 40) begin
      #1;
      if (stall_out) stalls++;
      tick();
      edges++;
      if (valid_out) break;
    end
    in_valid = 1'b0;
    total++;
    if (edges != 12) begin bad++; $display("FAIL mul_latency %0d*%0d: got %0d edges want 12", a, b, edges); end
    total++;
    if (stalls != 11) begin bad++; $display("FAIL mul_stall %0d*%0d: got %0d cycles want 11", a, b, stalls); end
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL mul_result: got %h want nothing queued", pack_got()); end
    else begin e = sb.pop_front();
      if (pack_got() !== pack_exp(e)) begin bad++; $display("FAIL mul_result %0d*%0d: got %h want %h", a, b, pack_got(), pack_exp(e)); end
    end
    set_defaults();
  endtask

  task automatic test_backpressure;
    exp_t held;
    set_defaults();
    issue(3'd0, 10'd100, 10'd23);
    tick();
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL bp_setup: got %h want nothing queued", pack_got()); end
    else begin held = sb.pop_front();
      if (pack_got() !== pack_exp(held)) begin bad++; $display("FAIL bp_setup: got %h want %h", pack_got(), pack_exp(held)); end
    end
    cache_Ready = 1'b0; rs_in = 10'd1; rt_in = 10'd2;
    tick(); tick();
    total++;
    if (pack_got() !== pack_exp(held)) begin bad++; $display("FAIL bp_hold_alu: got %h want %h", pack_got(), pack_exp(held)); end
    in_valid = 1'b0; cache_Ready = 1'b1;
    issue(3'b101, 10'd7, 10'd9);
    repeat (11) tick();
    cache_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (stall_out !== 1'b1) begin bad++; $display("FAIL bp_stall[%0d]: got %b want 1", i, stall_out); end
      tick();
      total++;
      if (valid_out !== 1'b0) begin bad++; $display("FAIL bp_hold_done[%0d]: got valid %b want 0", i, valid_out); end
    end
    cache_Ready = 1'b1;
    #1;
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL bp_release_stall: got %b want 0", stall_out); end
    tick();
    in_valid = 1'b0;
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL bp_product: got %h want nothing queued", pack_got()); end
    else begin e = sb.pop_front();
      if (pack_got() !== pack_exp(e)) begin bad++; $display("FAIL bp_product: got %h want %h", pack_got(), pack_exp(e)); end
    end
    set_defaults();
  endtask

  task automatic test_flush;
    set_defaults();
    issue(3'd0, 10'd5, 10'd6);
    tick();
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL flush_setup: got %h want nothing queued", pack_got()); end
    else begin e = sb.pop_front();
      if (pack_got() !== pack_exp(e)) begin bad++; $display("FAIL flush_setup: got %h want %h", pack_got(), pack_exp(e)); end
    end
    // Multiply runs under backpressure so the earlier result is still held.
    cache_Ready = 1'b0;
    in_valid = 1'b1; alu_sel = 3'b101; rs_in = 10'd12; rt_in = 10'd13;
    repeat (5) tick();
    total++;
    if (valid_out !== 1'b1) begin bad++; $display("FAIL flush_pre_hold: got valid %b want 1", valid_out); end
    flush = 1'b1; alu_sel = 3'd0; rs_in = 10'd5; rt_in = 10'd7;
    tick();
    total++;
    if ({valid_out, reg_write_en_out} !== 2'b00) begin bad++; $display("FAIL flush_bubble: got valid/we %b%b want 00", valid_out, reg_write_en_out); end
    flush = 1'b0; cache_Ready = 1'b1;
    issue(3'd0, 10'd8, 10'd9);
    #1;
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_idle_stall: got %b want 0", stall_out); end
    tick();
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL flush_next_add: got %h want nothing queued", pack_got()); end
    else begin e = sb.pop_front();
      if (pack_got() !== pack_exp(e)) begin bad++; $display("FAIL flush_next_add: got %h want %h", pack_got(), pack_exp(e)); end
    end
    set_defaults();
  endtask

  task automatic test_async_reset;
    set_defaults();
    in_valid = 1'b1; alu_sel = 3'b101; rs_in = 10'd3; rt_in = 10'd3;
    repeat (4) tick();
    reset = 1'b0;
    #1;
    total++;
    if (pack_got() !== '0) begin bad++; $display("FAIL async_reset_outputs: got %h want 0", pack_got()); end
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL async_reset_stall: got %b want 0", stall_out); end
    tick();
    reset = 1'b1;
    set_defaults();
    issue(3'd0, 10'd4, 10'd5);
    tick();
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL post_reset_add: got %h want nothing queued", pack_got()); end
    else begin e = sb.pop_front();
      if (pack_got() !== pack_exp(e)) begin bad++; $display("FAIL post_reset_add: got %h want %h", pack_got(), pack_exp(e)); end
    end
    set_defaults();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_m_load();
    test_back_to_back();
    test_multiply(10'd12, 10'd13);
    test_multiply(10'd40, 10'd30);
    test_backpressure();
    test_flush();
    test_async_reset();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
